// File: rtl/host_msg_pkg.sv
// Shared types and constants for the host word transmit path.
// Frame layout is fixed 8N1: one start bit, eight data bits, one stop bit.
package host_msg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int CHAR_W         = 8;
    localparam int BITS_PER_FRAME = 10;

endpackage

// File: rtl/host_msg_tx_if.sv
// Host-side bus of the word transmitter: request/word/abort in, line and status out.
interface host_msg_tx_if #(
    parameter int NUM_CHARS = 5
);
    import host_msg_pkg::*;

    logic                        send;
    logic [CHAR_W*NUM_CHARS-1:0] temp_word;
    logic                        gameEnd_host;
    logic                        tx_serial;
    logic                        busy;
    logic                        tx_done;

    modport master (
        output send,
        output temp_word,
        output gameEnd_host,
        input  tx_serial,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  send,
        input  temp_word,
        input  gameEnd_host,
        output tx_serial,
        output busy,
        output tx_done
    );

endinterface

// File: rtl/host_msg_tx_uart_byte_tx.sv
// Byte-level 8N1 serializer with baud counter; chains frames back-to-back
// when told more characters follow, so there is no gap between characters.
module uart_byte_tx
    import host_msg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              start,
    input  logic              chain,
    input  logic [CHAR_W-1:0] data_in,
    output logic              tx_serial,
    output logic              idle,
    output logic              frame_end
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(CHAR_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CHAR_W - 1);

    tx_state_t         state_reg, state_next;
    logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [CHAR_W-1:0] shift_reg, shift_next;
    logic              tx_serial_reg, tx_serial_next;
    logic              baud_last;

    assign baud_last = (baud_cnt_reg == BAUD_LAST);
    assign idle      = (state_reg == IDLE);
    assign frame_end = (state_reg == STOP) && baud_last;
    assign tx_serial = tx_serial_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            baud_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            tx_serial_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            tx_serial_reg <= tx_serial_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        baud_cnt_next  = baud_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        tx_serial_next = 1'b1;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = START;
                    baud_cnt_next = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    shift_next    = data_in;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    shift_next    = shift_reg >> 1;
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    state_next    = chain ? START : IDLE;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next    = IDLE;
            baud_cnt_next = '0;
            bit_cnt_next  = '0;
            shift_next    = '0;
        end

        // Line is registered from the next state so it lines up with busy.
        case (state_next)
            START:   tx_serial_next = 1'b0;
            DATA:    tx_serial_next = shift_next[0];
            default: tx_serial_next = 1'b1;
        endcase
    end

endmodule

// File: rtl/host_msg_tx.sv
// Serializes the captured host word MSB character first over one 8N1 line,
// reporting busy/tx_done; gameEnd_host aborts the word in flight.
module host_msg_tx
    import host_msg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int NUM_CHARS    = 5
) (
    input  logic         clk,
    input  logic         rst,
    host_msg_tx_if.slave bus
);

    localparam int WORD_W = CHAR_W * NUM_CHARS;
    localparam int IDX_W  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHARS - 1);

    logic [WORD_W-1:0] word_reg, word_next, word_shifted;
    logic [IDX_W-1:0]  char_idx_reg, char_idx_next;
    logic              tx_done_reg, tx_done_next;
    logic              abort;
    logic              accept;
    logic              more_chars;
    logic              byte_idle;
    logic              frame_end;
    logic              tx_line;

    assign abort      = bus.gameEnd_host;
    assign more_chars = (char_idx_reg != IDX_LAST);
    assign accept     = byte_idle && bus.send && !abort;

    // Next character moves into the top lane; bottom lane fills with zero.
    generate
        for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_lane
            if (gi == 0) begin : g_bottom
                assign word_shifted[CHAR_W-1:0] = '0;
            end else begin : g_upper
                assign word_shifted[gi*CHAR_W +: CHAR_W] = word_reg[(gi-1)*CHAR_W +: CHAR_W];
            end
        end
    endgenerate

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk      (clk),
        .rst      (rst),
        .abort    (abort),
        .start    (bus.send),
        .chain    (more_chars),
        .data_in  (word_reg[WORD_W-1 -: CHAR_W]),
        .tx_serial(tx_line),
        .idle     (byte_idle),
        .frame_end(frame_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg     <= '0;
            char_idx_reg <= '0;
            tx_done_reg  <= 1'b0;
        end else begin
            word_reg     <= word_next;
            char_idx_reg <= char_idx_next;
            tx_done_reg  <= tx_done_next;
        end
    end

    always_comb begin
        word_next     = word_reg;
        char_idx_next = char_idx_reg;
        tx_done_next  = 1'b0;

        if (abort) begin
            char_idx_next = '0;
        end else if (accept) begin
            word_next     = bus.temp_word;
            char_idx_next = '0;
        end else if (frame_end) begin
            if (more_chars) begin
                word_next     = word_shifted;
                char_idx_next = char_idx_reg + IDX_W'(1);
            end else begin
                tx_done_next = 1'b1;
            end
        end
    end

    assign bus.tx_serial = tx_line;
    assign bus.busy      = !byte_idle;
    assign bus.tx_done   = tx_done_reg;

endmodule

// File: tb/tb_host_msg_tx.sv
// Self-checking bench: logs the line every cycle and compares each frame
// against the waveform expected from the word's characters.
module tb_host_msg_tx;
    import host_msg_pkg::*;

    localparam int CPB      = 4;
    localparam int NC       = 5;
    localparam int FRAME    = BITS_PER_FRAME * CPB;
    localparam int WORD_CYC = NC * FRAME;
    localparam int HMAX     = 8192;

    typedef struct {
        logic [39:0] word;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
    } vec_t;

    logic tb_clk = 1'b0;
    logic rst    = 1'b1;

    host_msg_tx_if #(.NUM_CHARS(NC)) hif ();

    host_msg_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_CHARS   (NC)
    ) dut (
        .clk(tb_clk),
        .rst(rst),
        .bus(hif)
    );

    always #5 tb_clk = ~tb_clk;

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    logic line_hist [HMAX];
    logic busy_hist [HMAX];
    logic done_hist [HMAX];

    always @(negedge tb_clk) begin
        if (cyc < HMAX) begin
            line_hist[cyc] = hif.tx_serial;
            busy_hist[cyc] = hif.busy;
            done_hist[cyc] = hif.tx_done;
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [7:0] char_of(input logic [39:0] w, input int k);
        logic [39:0] t;
        t = w >> (8 * (NC - 1 - k));
        return t[7:0];
    endfunction

    // Ideal 8N1 waveform for one character, one entry per clock.
    function automatic logic [FRAME-1:0] exp_frame(input logic [7:0] b);
        logic [FRAME-1:0] f;
        logic v;
        for (int j = 0; j < BITS_PER_FRAME; j++) begin
            if (j == 0)                       v = 1'b0;
            else if (j == BITS_PER_FRAME - 1) v = 1'b1;
            else                              v = b[j-1];
            for (int s = 0; s < CPB; s++) f[j*CPB + s] = v;
        end
        return f;
    endfunction

    function automatic logic [FRAME-1:0] got_frame(input int start);
        logic [FRAME-1:0] f;
        for (int i = 0; i < FRAME; i++) f[i] = line_hist[start + i];
        return f;
    endfunction

    function automatic logic [7:0] decode_byte(input int start);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = line_hist[start + CPB*(i+1) + CPB/2];
        return b;
    endfunction

    task automatic send_word(input logic [39:0] w, output int a);
        hif.temp_word = w;
        hif.send      = 1'b1;
        a = cyc + 1;
        tick();
        hif.send = 1'b0;
    endtask

    task automatic check_word(input string tag, input int a, input logic [39:0] w);
        int n;
        tick_to(a + WORD_CYC + 3);
        for (int k = 0; k < NC; k++)
            chk($sformatf("%s_frame%0d", tag, k), 64'(got_frame(a + k*FRAME)), 64'(exp_frame(char_of(w, k))));
        n = 0;
        while (n < WORD_CYC + 5 && busy_hist[a + n] === 1'b1) n++;
        chk({tag, "_busy_len"}, 64'(n), 64'(WORD_CYC));
        chk({tag, "_done_pos"},
            {61'd0, done_hist[a+WORD_CYC-1], done_hist[a+WORD_CYC], done_hist[a+WORD_CYC+1]}, 64'b010);
    endtask

    task automatic check_quiet(input string tag, input int from, input int to);
        int bad;
        tick_to(to + 2);
        bad = 0;
        for (int c = from; c <= to; c++)
            if (line_hist[c] !== 1'b1 || busy_hist[c] !== 1'b0 || done_hist[c] !== 1'b0) bad++;
        chk(tag, 64'(bad), 64'd0);
    endtask

    vec_t tbl [5];

    initial begin
        int a, spur, t0;
        int done_at [$];
        logic [39:0] w, w2;

        tbl[0] = '{word: 40'h46414E5441, exp_first: 8'h46, exp_last: 8'h41};
        tbl[1] = '{word: 40'h0000000000, exp_first: 8'h00, exp_last: 8'h00};
        tbl[2] = '{word: 40'h5F5F5F5F5F, exp_first: 8'h5F, exp_last: 8'h5F};
        tbl[3] = '{word: 40'hFF00A5015F, exp_first: 8'hFF, exp_last: 8'h5F};
        tbl[4] = '{word: 40'h0102030480, exp_first: 8'h01, exp_last: 8'h80};

        hif.send         = 1'b0;
        hif.temp_word    = '0;
        hif.gameEnd_host = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_line", 64'(hif.tx_serial), 64'd1);
        chk("reset_busy", 64'(hif.busy), 64'd0);
        chk("reset_done", 64'(hif.tx_done), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Table-driven single words
        for (int i = 0; i < 5; i++) begin
            send_word(tbl[i].word, a);
            check_word($sformatf("tbl%0d", i), a, tbl[i].word);
            chk($sformatf("tbl%0d_first", i), 64'(decode_byte(a)), 64'(tbl[i].exp_first));
            chk($sformatf("tbl%0d_last", i), 64'(decode_byte(a + (NC-1)*FRAME)), 64'(tbl[i].exp_last));
            repeat (3) tick();
        end

        // Send while busy is ignored
        send_word(40'h46414E5441, a);
        tick_to(a + 50);
        hif.temp_word = 40'h5F5F5F5F5F;
        hif.send      = 1'b1;
        tick();
        hif.send = 1'b0;
        check_word("guard", a, 40'h46414E5441);
        check_quiet("guard_quiet", a + WORD_CYC + 1, a + WORD_CYC + 30);

        // temp_word changes after capture
        send_word(40'h1234567890, a);
        hif.temp_word = 40'hDEADBEEF00;
        tick();
        hif.temp_word = 40'hA5A5A5A5A5;
        check_word("stable", a, 40'h1234567890);

        // Abort mid-word, then retransmit from the first character
        send_word(40'h46414E5441, a);
        tick_to(a + 72);
        hif.gameEnd_host = 1'b1;
        tick();
        hif.gameEnd_host = 1'b0;
        chk("abort_line", 64'(hif.tx_serial), 64'd1);
        chk("abort_busy", 64'(hif.busy), 64'd0);
        check_quiet("abort_quiet", a + 73, a + 260);
        send_word(40'h46414E5441, a);
        check_word("retx", a, 40'h46414E5441);

        // Abort and send together: abort wins
        tick();
        t0 = cyc + 1;
        hif.temp_word    = 40'h4142434445;
        hif.send         = 1'b1;
        hif.gameEnd_host = 1'b1;
        tick();
        hif.send         = 1'b0;
        hif.gameEnd_host = 1'b0;
        check_quiet("abort_send_quiet", t0, t0 + 30);

        // Reset mid-word
        send_word(40'h46414E5441, a);
        tick_to(a + 60);
        rst = 1'b1;
        tick();
        chk("midrst_line", 64'(hif.tx_serial), 64'd1);
        chk("midrst_busy", 64'(hif.busy), 64'd0);
        chk("midrst_done", 64'(hif.tx_done), 64'd0);
        tick();
        rst = 1'b0;
        check_quiet("midrst_quiet", a + 61, a + 320);

        // Back-to-back words with send held high
        w = 40'h46414E5441;
        hif.temp_word = w;
        hif.send      = 1'b1;
        a = cyc + 1;
        tick_to(a + 399);
        hif.send = 1'b0;
        check_word("b2b1", a, w);
        check_word("b2b2", a + WORD_CYC + 1, w);
        tick_to(a + 430);
        done_at.delete();
        for (int c = a; c <= a + 425; c++)
            if (done_hist[c] === 1'b1) done_at.push_back(c);
        chk("b2b_done_count", 64'(done_at.size()), 64'd2);
        if (done_at.size() == 2)
            chk("b2b_done_gap", 64'(done_at[1] - done_at[0]), 64'd201);
        check_quiet("b2b_quiet", a + 2*WORD_CYC + 2, a + 2*WORD_CYC + 25);

        // Randomized words with spurious sends and a wandering temp_word
        for (int r = 0; r < 8; r++) begin
            w = {$urandom_range(0, 255), $urandom};
            repeat ($urandom_range(0, 6)) tick();
            send_word(w, a);
            spur = $urandom_range(1, WORD_CYC - 10);
            while (cyc < a + WORD_CYC - 1) begin
                w2 = {$urandom_range(0, 255), $urandom};
                hif.temp_word = w2;
                hif.send      = (cyc + 1 == a + spur);
                tick();
            end
            hif.send = 1'b0;
            check_word($sformatf("rnd%0d", r), a, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
